display_frame_scheduler: RTL

//  Double-buffered frame buffer controller in front of display_driver. A render

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_fb_writer.sv | 91 +++++++++
 rtl/display_frame_scheduler.sv | 111 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display frame scheduler and display_driver benches:
// FSM state encodings and the address/pixel width derivations.
package display_pkg;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  function automatic int calc_aw(input int rows, input int columns);
    return $clog2(rows) + $clog2(columns);
  endfunction

  function automatic int calc_pw(input int bitwidth, input int segments);
    return bitwidth * 3 * segments;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/display_fb_writer.sv
// Back-page write port: raster pointer, frame length check and the registered
// BRAM write interface.
module display_fb_writer
  import display_pkg::*;
#(
  parameter int AW       = 8,
  parameter int PW       = 24,
  parameter int SEGMENTS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          wr_last,
  input  logic [PW-1:0] wr_data,
  input  logic          back_page,
  input  logic          clear,
  output logic          frame_done,
  output logic          mem_we,
  output logic [AW:0]   mem_waddr,
  output logic [PW-1:0] mem_wdata,
  output logic          err_len
);

  localparam int SW = PW / SEGMENTS;
  // The page holds exactly 2^AW pixels, so the final pixel index is all ones.
  localparam logic [AW-1:0] LAST_PTR = '1;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          err_len_reg, err_len_next;
  logic          mem_we_reg;
  logic [AW:0]   mem_waddr_reg;
  logic          at_end;

  assign at_end     = (wr_ptr_reg == LAST_PTR);
  assign frame_done = accept && wr_last && at_end;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    err_len_next = err_len_reg;
    if (clear) begin
      wr_ptr_next = '0;
    end else if (accept) begin
      if (wr_last && !at_end) begin
        // Short frame: drop it and restart the page from pixel 0.
        wr_ptr_next  = '0;
        err_len_next = 1'b1;
      end else begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        if (at_end && !wr_last) begin
          err_len_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      err_len_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      err_len_reg <= err_len_next;
      mem_we_reg  <= accept;
      if (accept) begin
        mem_waddr_reg <= {back_page, wr_ptr_reg};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SEGMENTS; gi++) begin : g_seg
      logic [SW-1:0] seg_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          seg_reg <= '0;
        end else if (accept) begin
          seg_reg <= wr_data[gi*SW +: SW];
        end
      end
      assign mem_wdata[gi*SW +: SW] = seg_reg;
    end
  endgenerate

  assign mem_we    = mem_we_reg;
  assign mem_waddr = mem_waddr_reg;
  assign err_len   = err_len_reg;

endmodule

// File: rtl/display_frame_scheduler.sv
// Double-buffered frame scheduler: renders into the back page and flips pages
// only at the driver's end of frame; holds the driver in reset until frame one.
module display_frame_scheduler
  import display_pkg::*;
#(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int AW = calc_aw(rows, columns),
  localparam int PW = calc_pw(bitwidth, segments),
  localparam int RW = $clog2(rows),
  localparam int CW = $clog2(columns)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_complete,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] column,
  output logic [AW:0]   rd_addr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [PW-1:0] wr_data,
  input  logic          wr_last,
  output logic          mem_we,
  output logic [AW:0]   mem_waddr,
  output logic [PW-1:0] mem_wdata,
  output logic          drv_rst,
  output logic          err_len,
  output logic [15:0]   frame_count
);

  generate
    if (!is_pow2(rows) || !is_pow2(columns) || (rows * columns != (1 << AW))) begin : g_bad_geom
      $error("display_frame_scheduler: rows and columns must be powers of two");
    end
  endgenerate

  logic [1:0]  state_reg, state_next;
  logic        disp_page_reg;
  logic        shown_reg;
  logic        drv_rst_reg;
  logic        ready_en_reg;
  logic [15:0] frame_count_reg;
  logic        accept;
  logic        frame_done;
  logic        in_swap;

  assign wr_ready = ready_en_reg && (state_reg == ST_FILL);
  assign accept   = wr_valid && wr_ready;
  assign in_swap  = (state_reg == ST_SWAP);
  // Purely combinational so the driver's address-to-pixel latency is untouched.
  assign rd_addr  = {disp_page_reg, row, column};

  display_fb_writer #(
    .AW       (AW),
    .PW       (PW),
    .SEGMENTS (segments)
  ) u_writer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .wr_last    (wr_last),
    .wr_data    (wr_data),
    .back_page  (~disp_page_reg),
    .clear      (in_swap),
    .frame_done (frame_done),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .err_len    (err_len)
  );

  // READY only looks at frame_complete while it is in READY, so a pulse that
  // coincides with the final FILL accept is deliberately ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL:  if (frame_done) state_next = ST_READY;
      ST_READY: if (!shown_reg || frame_complete) state_next = ST_SWAP;
      ST_SWAP:  state_next = ST_FILL;
      default:  state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_FILL;
      disp_page_reg   <= 1'b0;
      shown_reg       <= 1'b0;
      drv_rst_reg     <= 1'b1;
      ready_en_reg    <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (in_swap) begin
        disp_page_reg <= ~disp_page_reg;
        shown_reg     <= 1'b1;
        drv_rst_reg   <= 1'b0;
      end
      if (frame_complete && !drv_rst_reg) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  assign drv_rst     = drv_rst_reg;
  assign frame_count = frame_count_reg;

endmodule
